button_conditioner: RTL and testbench

Input-conditioning stage between the stopwatch's raw push-buttons and its button state machine. Each of NBTN asynchronous button inputs is synchronised to `mclk`, debounced with a per-button stability counter, and turned into a clean level, one-cycle press/release strobes and a one-shot long-press strobe. The button state machine consumes these signals in place of the raw pins.

---
 rtl/button_conditioner.sv | 154 +++++++++++++++
 tb/tb_button_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and classify NBTN raw push-buttons into level, press/release and long-press strobes.
// Latency: a raw change sampled at edge k shows on btn_level and its strobe at edge k + 2 + DEBOUNCE_CYCLES.
// Backpressure: none; strobes are single-cycle pulses that the consumer must sample every cycle.
module button_conditioner #(
  parameter int NBTN            = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic            mclk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // p = 1 always means "pressed", whatever the pin polarity
  logic [NBTN-1:0] p;
  logic [NBTN-1:0] s1;
  logic [NBTN-1:0] s2;

  assign p = btn_raw ^ {NBTN{ACTIVE_LOW}};

  // Two-flop synchroniser; only s2 is allowed to feed any logic
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    // Debounced level held next to its stability counter
    logic          deb_q;
    logic [DW-1:0] dcnt_q;

    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_d;

    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic          release_q;
    logic          release_d;
    logic          long_q;
    logic          long_d;

    // Accept a change of s2 only after it has differed from the debounced level for DEBOUNCE_CYCLES edges in a row
    always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
        deb_q  <= 1'b0;
        dcnt_q <= '0;
      end else if (s2[i] == deb_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == DB_LAST) begin
        deb_q  <= ~deb_q;
        dcnt_q <= '0;
      end else begin
        dcnt_q <= dcnt_q + DW'(1);
      end
    end

    // FSM state, hold counter and all registered outputs
    always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
        state_q   <= ST_IDLE;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        hcnt_q    <= hcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    // Next state: a release always wins over a long-press that would land on the same edge
    always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          hcnt_d = '0;
          if (deb_q) begin
            state_d = ST_PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!deb_q) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            hcnt_d    = '0;
          end else if (hcnt_q == HOLD_LAST) begin
            // Counter stays at its last value: no repeat, no wrap
            state_d = ST_HELD;
            long_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        ST_HELD: begin
          if (!deb_q) begin
            state_d   = ST_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            hcnt_d    = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          hcnt_d  = '0;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/hold constants.
// Expected strobes are queued with the edge they must appear on; monitors pop and compare them.
// An active-high and an active-low instance share the clock and reset.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int HC = 10;
  localparam int LAT = DB + 3;  // from the negedge that drives raw to the edge of the strobe

  logic       mclk;
  logic       reset;
  logic [2:0] raw0, raw1;
  logic [2:0] lv0, pr0, rl0, lg0;
  logic [2:0] lv1, pr1, rl1, lg1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    int         at;
    logic [2:0] pr;
    logic [2:0] rl;
    logic [2:0] lg;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  button_conditioner #(.NBTN(3), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .ACTIVE_LOW(1'b0)) u_dut (
    .mclk(mclk), .reset(reset), .btn_raw(raw0),
    .btn_level(lv0), .btn_press(pr0), .btn_release(rl0), .btn_long(lg0)
  );

  button_conditioner #(.NBTN(3), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .ACTIVE_LOW(1'b1)) u_dut_al (
    .mclk(mclk), .reset(reset), .btn_raw(raw1),
    .btn_level(lv1), .btn_press(pr1), .btn_release(rl1), .btn_long(lg1)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Edge number: after posedge n, cyc == n
  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp0(input int at, input logic [2:0] pr, input logic [2:0] rl, input logic [2:0] lg);
    ev_t e;
    e.at = at; e.pr = pr; e.rl = rl; e.lg = lg;
    q0.push_back(e);
  endtask

  task automatic exp1(input int at, input logic [2:0] pr, input logic [2:0] rl, input logic [2:0] lg);
    ev_t e;
    e.at = at; e.pr = pr; e.rl = rl; e.lg = lg;
    q1.push_back(e);
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Scoreboard for the active-high instance
  always @(posedge mclk) begin
    ev_t e;
    #1;
    while (q0.size() > 0 && q0[0].at < cyc) begin
      e = q0.pop_front();
      check("u0 strobe missed (edge)", cyc, e.at);
    end
    if ((pr0 | rl0 | lg0) != 3'b000 || (q0.size() > 0 && q0[0].at == cyc)) begin
      if (q0.size() == 0) begin
        check("u0 unexpected strobe", {pr0, rl0, lg0}, 9'd0);
      end else begin
        e = q0.pop_front();
        check("u0 strobe edge", cyc, e.at);
        check("u0 press", pr0, e.pr);
        check("u0 release", rl0, e.rl);
        check("u0 long", lg0, e.lg);
      end
    end
  end

  // Scoreboard for the active-low instance
  always @(posedge mclk) begin
    ev_t e;
    #1;
    while (q1.size() > 0 && q1[0].at < cyc) begin
      e = q1.pop_front();
      check("u1 strobe missed (edge)", cyc, e.at);
    end
    if ((pr1 | rl1 | lg1) != 3'b000 || (q1.size() > 0 && q1[0].at == cyc)) begin
      if (q1.size() == 0) begin
        check("u1 unexpected strobe", {pr1, rl1, lg1}, 9'd0);
      end else begin
        e = q1.pop_front();
        check("u1 strobe edge", cyc, e.at);
        check("u1 press", pr1, e.pr);
        check("u1 release", rl1, e.rl);
        check("u1 long", lg1, e.lg);
      end
    end
  end

  initial begin
    reset = 1'b0;
    raw0  = 3'b000;
    raw1  = 3'b111;
    nedge(2);
    check("reset level", lv0, 3'b000);
    check("reset press", pr0, 3'b000);
    check("reset release", rl0, 3'b000);
    check("reset long", lg0, 3'b000);
    check("reset level al", lv1, 3'b000);
    reset = 1'b1;
    nedge(3);

    // Clean press on bit 0, held long enough for a long-press too
    raw0[0] = 1'b1;
    exp0(cyc + LAT, 3'b001, 3'b000, 3'b000);
    exp0(cyc + LAT + HC, 3'b000, 3'b000, 3'b001);
    nedge(LAT - 1);
    check("clean level not early", lv0, 3'b000);
    nedge(1);
    check("clean level", lv0, 3'b001);
    check("clean press", pr0, 3'b001);
    nedge(HC + 2);

    // Bounce on bit 1, then toggling every DB-1 cycles: never accepted
    raw0[1] = 1'b1; nedge(3);
    raw0[1] = 1'b0; nedge(2);
    raw0[1] = 1'b1; nedge(3);
    raw0[1] = 1'b0; nedge(3);
    for (int i = 0; i < 4; i++) begin
      raw0[1] = 1'b1; nedge(DB - 1);
      raw0[1] = 1'b0; nedge(DB - 1);
    end
    nedge(10);
    check("bounce level", lv0, 3'b001);

    // Long press on bit 2, held 30 more cycles, then released
    raw0[2] = 1'b1;
    exp0(cyc + LAT, 3'b100, 3'b000, 3'b000);
    exp0(cyc + LAT + HC, 3'b000, 3'b000, 3'b100);
    nedge(LAT + HC + 30);
    check("long held level", lv0, 3'b101);
    raw0[2] = 1'b0;
    exp0(cyc + LAT, 3'b000, 3'b100, 3'b000);
    nedge(LAT - 1);
    check("long release not early", lv0, 3'b101);
    nedge(1);
    check("long release level", lv0, 3'b001);
    check("long release strobe", rl0, 3'b100);

    // Release bit 0, then a short press that ends before the hold time
    raw0[0] = 1'b0;
    exp0(cyc + LAT, 3'b000, 3'b001, 3'b000);
    nedge(LAT + 1);
    check("bit0 released level", lv0, 3'b000);
    raw0[0] = 1'b1;
    exp0(cyc + LAT, 3'b001, 3'b000, 3'b000);
    nedge(LAT);
    raw0[0] = 1'b0;
    exp0(cyc + LAT, 3'b000, 3'b001, 3'b000);
    nedge(HC + 8);
    check("short press level", lv0, 3'b000);

    // Simultaneous press, reset mid-hold, fresh press after reset
    raw0 = 3'b101;
    exp0(cyc + LAT, 3'b101, 3'b000, 3'b000);
    nedge(LAT);
    check("simul press", pr0, 3'b101);
    check("simul level", lv0, 3'b101);
    nedge(2);
    reset = 1'b0;
    #1;
    check("async reset level", lv0, 3'b000);
    check("async reset press", pr0, 3'b000);
    check("async reset release", rl0, 3'b000);
    check("async reset long", lg0, 3'b000);
    nedge(2);
    reset = 1'b1;
    exp0(cyc + LAT, 3'b101, 3'b000, 3'b000);
    nedge(LAT - 1);
    check("post-reset not early", lv0, 3'b000);
    nedge(1);
    check("post-reset press", pr0, 3'b101);
    raw0 = 3'b000;
    exp0(cyc + LAT, 3'b000, 3'b101, 3'b000);
    nedge(LAT + 1);
    check("post-reset released", lv0, 3'b000);

    // Active-low instance: all pins high means nothing pressed; pull bit 1 low
    check("al idle level", lv1, 3'b000);
    raw1[1] = 1'b0;
    exp1(cyc + LAT, 3'b010, 3'b000, 3'b000);
    nedge(LAT);
    check("al press level", lv1, 3'b010);
    check("al press strobe", pr1, 3'b010);
    raw1[1] = 1'b1;
    exp1(cyc + LAT, 3'b000, 3'b010, 3'b000);
    nedge(LAT + 1);
    check("al release level", lv1, 3'b000);

    nedge(20);
    check("u0 queue drained", q0.size(), 0);
    check("u1 queue drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
